// File: rtl/rename_map_table_pkg.sv
// rtl/rename_map_table_pkg.sv - shared widths, map/tag types and helpers for the rename map table
package rename_map_table_pkg;
    localparam int NUM_ARCH = 8;
    localparam int PTAG_W   = 5;
    localparam int RN_W     = 2;
    localparam int CM_W     = 2;
    localparam int NUM_CKPT = 4;
    localparam int AREG_W   = $clog2(NUM_ARCH);
    localparam int CKPT_W   = $clog2(NUM_CKPT);

    typedef logic [AREG_W-1:0]              areg_t;
    typedef logic [PTAG_W-1:0]              ptag_t;
    typedef logic [CKPT_W-1:0]              ckpt_id_t;
    typedef ptag_t [NUM_ARCH-1:0]           map_t;

    function automatic map_t identity_map();
        map_t m;
        for (int i = 0; i < NUM_ARCH; i++) begin
            m[i] = ptag_t'(i);
        end
        return m;
    endfunction
endpackage

// File: rtl/rename_map_table_if.sv
// rtl/rename_map_table_if.sv - rename, branch, commit and flush signals of the rename map table
interface rename_map_table_if;
    import rename_map_table_pkg::*;

    logic [RN_W-1:0]        rn_valid;
    logic [RN_W*AREG_W-1:0] rn_src1;
    logic [RN_W*AREG_W-1:0] rn_src2;
    logic [RN_W-1:0]        rn_wr;
    logic [RN_W*AREG_W-1:0] rn_dst;
    logic [RN_W*PTAG_W-1:0] rn_ptag;
    logic [RN_W*PTAG_W-1:0] rn_psrc1;
    logic [RN_W*PTAG_W-1:0] rn_psrc2;
    logic [RN_W*PTAG_W-1:0] rn_pold;
    logic                   ckpt_req;
    ckpt_id_t               ckpt_id;
    logic                   ckpt_full;
    logic                   rn_accept;
    logic                   br_valid;
    ckpt_id_t               br_id;
    logic                   br_mispred;
    logic [CM_W-1:0]        cm_valid;
    logic [CM_W-1:0]        cm_wr;
    logic [CM_W*AREG_W-1:0] cm_dst;
    logic [CM_W*PTAG_W-1:0] cm_ptag;
    logic                   flush;

    modport master (
        output rn_valid, rn_src1, rn_src2, rn_wr, rn_dst, rn_ptag, ckpt_req,
               br_valid, br_id, br_mispred, cm_valid, cm_wr, cm_dst, cm_ptag, flush,
        input  rn_psrc1, rn_psrc2, rn_pold, ckpt_id, ckpt_full, rn_accept
    );

    modport slave (
        input  rn_valid, rn_src1, rn_src2, rn_wr, rn_dst, rn_ptag, ckpt_req,
               br_valid, br_id, br_mispred, cm_valid, cm_wr, cm_dst, cm_ptag, flush,
        output rn_psrc1, rn_psrc2, rn_pold, ckpt_id, ckpt_full, rn_accept
    );
endinterface

// File: rtl/rename_map_table_ckpt_ring.sv
// rtl/rename_map_table_ckpt_ring.sv - branch checkpoint ring: snapshots, valid/resolved bits, head/tail/count
module rename_map_table_ckpt_ring
    import rename_map_table_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     flush_i,
    input  logic     alloc_i,
    input  map_t     alloc_map_i,
    input  logic     resolve_i,
    input  logic     mispred_i,
    input  ckpt_id_t br_id_i,
    output ckpt_id_t tail_o,
    output logic     full_o,
    output logic     br_live_o,
    output map_t     br_map_o
);
    typedef logic [CKPT_W:0] cnt_t;

    ckpt_id_t            head_q, head_d, tail_q, tail_d;
    cnt_t                count_q, count_d, n_free;
    logic [NUM_CKPT-1:0] valid_q, valid_d, res_q, res_d, res_eff, free_mask;
    logic                walking;
    ckpt_id_t            idx, d_br, d_i;
    map_t                snap_q [NUM_CKPT];

    assign tail_o    = tail_q;
    assign full_o    = (count_q == cnt_t'(NUM_CKPT));
    assign br_live_o = valid_q[br_id_i];
    assign br_map_o  = snap_q[br_id_i];

    always_comb begin
        res_eff = res_q;
        if (resolve_i && valid_q[br_id_i]) begin
            res_eff[br_id_i] = 1'b1;
        end
        // Retire the in-order run of resolved checkpoints starting at head.
        free_mask = '0;
        n_free    = '0;
        walking   = 1'b1;
        idx       = head_q;
        for (int i = 0; i < NUM_CKPT; i++) begin
            idx = head_q + ckpt_id_t'(i);
            if (walking && valid_q[idx] && res_eff[idx]) begin
                free_mask[idx] = 1'b1;
                n_free         = n_free + cnt_t'(1);
            end else begin
                walking = 1'b0;
            end
        end

        head_d  = head_q + ckpt_id_t'(n_free);
        tail_d  = tail_q;
        count_d = count_q - n_free;
        valid_d = valid_q & ~free_mask;
        res_d   = res_eff & ~free_mask;
        d_br    = br_id_i - head_q;
        d_i     = '0;

        if (alloc_i) begin
            valid_d[tail_q] = 1'b1;
            res_d[tail_q]   = 1'b0;
            tail_d          = tail_q + ckpt_id_t'(1);
            count_d         = count_d + cnt_t'(1);
        end

        if (mispred_i && valid_q[br_id_i]) begin
            // Everything younger than the mispredicted branch is wrong-path.
            for (int i = 0; i < NUM_CKPT; i++) begin
                d_i = ckpt_id_t'(i) - head_q;
                if (d_i > d_br) begin
                    valid_d[i] = 1'b0;
                    res_d[i]   = 1'b0;
                end
            end
            tail_d  = br_id_i + ckpt_id_t'(1);
            count_d = cnt_t'(d_br) + cnt_t'(1);
        end

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            res_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_i) begin
            snap_q[tail_q] <= alloc_map_i;
        end
    end

    br_id_live: assert property (@(posedge clk) disable iff (!rst)
        (resolve_i || mispred_i) |-> valid_q[br_id_i]);
endmodule

// File: rtl/rename_map_table.sv
// rtl/rename_map_table.sv - speculative and committed register alias tables with group bypass and recovery
module rename_map_table
    import rename_map_table_pkg::*;
(
    input logic               clk,
    input logic               rst,
    rename_map_table_if.slave rmt
);
    map_t     spec_q, spec_d, cmt_q, cmt_d, spec_grp, br_map;
    areg_t    src1_a [RN_W];
    areg_t    src2_a [RN_W];
    areg_t    dst_a  [RN_W];
    ptag_t    ptag_a [RN_W];
    areg_t    cm_dst_a  [CM_W];
    ptag_t    cm_ptag_a [CM_W];
    logic [RN_W-1:0] rn_wen;
    logic [CM_W-1:0] cm_wen;
    logic     mispred, resolve, accept, alloc, br_live;
    ckpt_id_t tail;
    logic     full;

    always_comb begin
        for (int k = 0; k < RN_W; k++) begin
            src1_a[k] = rmt.rn_src1[k*AREG_W +: AREG_W];
            src2_a[k] = rmt.rn_src2[k*AREG_W +: AREG_W];
            dst_a[k]  = rmt.rn_dst[k*AREG_W +: AREG_W];
            ptag_a[k] = rmt.rn_ptag[k*PTAG_W +: PTAG_W];
            rn_wen[k] = rmt.rn_valid[k] & rmt.rn_wr[k] & (dst_a[k] != '0);
        end
        for (int k = 0; k < CM_W; k++) begin
            cm_dst_a[k]  = rmt.cm_dst[k*AREG_W +: AREG_W];
            cm_ptag_a[k] = rmt.cm_ptag[k*PTAG_W +: PTAG_W];
            cm_wen[k]    = rmt.cm_valid[k] & rmt.cm_wr[k] & (cm_dst_a[k] != '0);
        end
    end

    // Ascending scan over older slots leaves the youngest matching writer in place.
    always_comb begin : lookup
        ptag_t t1, t2, to;
        rmt.rn_psrc1 = '0;
        rmt.rn_psrc2 = '0;
        rmt.rn_pold  = '0;
        for (int k = 0; k < RN_W; k++) begin
            t1 = spec_q[src1_a[k]];
            t2 = spec_q[src2_a[k]];
            to = spec_q[dst_a[k]];
            for (int j = 0; j < k; j++) begin
                if (rn_wen[j] && dst_a[j] == src1_a[k]) t1 = ptag_a[j];
                if (rn_wen[j] && dst_a[j] == src2_a[k]) t2 = ptag_a[j];
                if (rn_wen[j] && dst_a[j] == dst_a[k])  to = ptag_a[j];
            end
            if (src1_a[k] == '0) t1 = '0;
            if (src2_a[k] == '0) t2 = '0;
            if (dst_a[k] == '0)  to = '0;
            rmt.rn_psrc1[k*PTAG_W +: PTAG_W] = t1;
            rmt.rn_psrc2[k*PTAG_W +: PTAG_W] = t2;
            rmt.rn_pold[k*PTAG_W +: PTAG_W]  = to;
        end
    end

    assign mispred       = rmt.br_valid & rmt.br_mispred & ~rmt.flush;
    assign resolve       = rmt.br_valid & ~rmt.br_mispred & ~rmt.flush;
    assign accept        = ~rmt.flush & ~(rmt.br_valid & rmt.br_mispred) & ~(rmt.ckpt_req & full);
    assign alloc         = rmt.ckpt_req & accept;
    assign rmt.rn_accept = accept;
    assign rmt.ckpt_id   = tail;
    assign rmt.ckpt_full = full;

    always_comb begin
        spec_grp = spec_q;
        for (int k = 0; k < RN_W; k++) begin
            if (rn_wen[k]) spec_grp[dst_a[k]] = ptag_a[k];
        end
        cmt_d = cmt_q;
        for (int k = 0; k < CM_W; k++) begin
            if (cm_wen[k]) cmt_d[cm_dst_a[k]] = cm_ptag_a[k];
        end
        // Flush outranks mispredict, which outranks the rename group.
        spec_d = spec_q;
        if (rmt.flush) begin
            spec_d = cmt_d;
        end else if (mispred) begin
            if (br_live) spec_d = br_map;
        end else if (accept) begin
            spec_d = spec_grp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_q <= identity_map();
            cmt_q  <= identity_map();
        end else begin
            spec_q <= spec_d;
            cmt_q  <= cmt_d;
        end
    end

    rename_map_table_ckpt_ring u_ring (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (rmt.flush),
        .alloc_i     (alloc),
        .alloc_map_i (spec_grp),
        .resolve_i   (resolve),
        .mispred_i   (mispred),
        .br_id_i     (rmt.br_id),
        .tail_o      (tail),
        .full_o      (full),
        .br_live_o   (br_live),
        .br_map_o    (br_map)
    );
endmodule

// File: tb/tb_rename_map_table.sv
// tb/tb_rename_map_table.sv - directed scoreboard bench for the rename map table
module tb_rename_map_table;
    import rename_map_table_pkg::*;

    logic clk;
    logic rst;
    rename_map_table_if rmt ();

    rename_map_table dut (
        .clk (clk),
        .rst (rst),
        .rmt (rmt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic expect_v(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle();
        rmt.rn_valid   = '0;
        rmt.rn_src1    = '0;
        rmt.rn_src2    = '0;
        rmt.rn_wr      = '0;
        rmt.rn_dst     = '0;
        rmt.rn_ptag    = '0;
        rmt.ckpt_req   = 1'b0;
        rmt.br_valid   = 1'b0;
        rmt.br_id      = '0;
        rmt.br_mispred = 1'b0;
        rmt.cm_valid   = '0;
        rmt.cm_wr      = '0;
        rmt.cm_dst     = '0;
        rmt.cm_ptag    = '0;
        rmt.flush      = 1'b0;
    endtask

    task automatic set_slot(input int k, input int wr, input int dst, input int s1, input int s2,
                            input int ptag);
        rmt.rn_valid[k]                  = 1'b1;
        rmt.rn_wr[k]                     = wr[0];
        rmt.rn_dst[k*AREG_W +: AREG_W]   = AREG_W'(dst);
        rmt.rn_src1[k*AREG_W +: AREG_W]  = AREG_W'(s1);
        rmt.rn_src2[k*AREG_W +: AREG_W]  = AREG_W'(s2);
        rmt.rn_ptag[k*PTAG_W +: PTAG_W]  = PTAG_W'(ptag);
    endtask

    task automatic set_commit(input int k, input int dst, input int ptag);
        rmt.cm_valid[k]                 = 1'b1;
        rmt.cm_wr[k]                    = 1'b1;
        rmt.cm_dst[k*AREG_W +: AREG_W]  = AREG_W'(dst);
        rmt.cm_ptag[k*PTAG_W +: PTAG_W] = PTAG_W'(ptag);
    endtask

    // Slot 0 has no older slots, so its lookup exposes the speculative map directly.
    task automatic peek_spec(input int a, input int exp);
        rmt.rn_src1[AREG_W-1:0] = AREG_W'(a);
        expect_v($sformatf("spec[%0d]", a), exp);
        #1;
        compare(32'(rmt.rn_psrc1[PTAG_W-1:0]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic logic [31:0] psrc1(input int k);
        return 32'(rmt.rn_psrc1[k*PTAG_W +: PTAG_W]);
    endfunction

    function automatic logic [31:0] psrc2(input int k);
        return 32'(rmt.rn_psrc2[k*PTAG_W +: PTAG_W]);
    endfunction

    function automatic logic [31:0] pold(input int k);
        return 32'(rmt.rn_pold[k*PTAG_W +: PTAG_W]);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;

        expect_v("reset_full", 0);
        expect_v("reset_ckpt_id", 0);
        expect_v("reset_accept", 1);
        compare(32'(rmt.ckpt_full));
        compare(32'(rmt.ckpt_id));
        compare(32'(rmt.rn_accept));
        peek_spec(1, 1);
        peek_spec(7, 7);

        set_slot(0, 1, 1, 2, 0, 8);
        set_slot(1, 1, 2, 1, 0, 9);
        expect_v("grp_psrc1_s0", 2);
        expect_v("grp_psrc1_s1", 8);
        expect_v("grp_psrc2_s1", 0);
        expect_v("grp_pold_s0", 1);
        expect_v("grp_pold_s1", 2);
        expect_v("grp_accept", 1);
        #1;
        compare(psrc1(0));
        compare(psrc1(1));
        compare(psrc2(1));
        compare(pold(0));
        compare(pold(1));
        compare(32'(rmt.rn_accept));
        tick();
        peek_spec(1, 8);
        peek_spec(2, 9);

        set_slot(0, 1, 3, 0, 0, 10);
        set_slot(1, 1, 3, 3, 0, 11);
        expect_v("samedst_pold_s0", 3);
        expect_v("samedst_pold_s1", 10);
        expect_v("samedst_psrc1_s1", 10);
        #1;
        compare(pold(0));
        compare(pold(1));
        compare(psrc1(1));
        tick();
        peek_spec(3, 11);

        set_slot(0, 1, 0, 0, 0, 20);
        set_slot(1, 1, 5, 0, 0, 21);
        expect_v("r0_pold_s0", 0);
        expect_v("r0_psrc1_s1", 0);
        #1;
        compare(pold(0));
        compare(psrc1(1));
        tick();
        peek_spec(0, 0);
        peek_spec(5, 21);

        for (int i = 0; i < NUM_CKPT; i++) begin
            rmt.ckpt_req = 1'b1;
            expect_v($sformatf("fill_ckpt_id%0d", i), i);
            expect_v($sformatf("fill_accept%0d", i), 1);
            #1;
            compare(32'(rmt.ckpt_id));
            compare(32'(rmt.rn_accept));
            tick();
        end
        expect_v("full_after_fill", 1);
        compare(32'(rmt.ckpt_full));

        rmt.ckpt_req = 1'b1;
        set_slot(0, 1, 6, 0, 0, 22);
        expect_v("full_accept", 0);
        #1;
        compare(32'(rmt.rn_accept));
        tick();
        peek_spec(6, 6);
        expect_v("full_ckpt_id", 0);
        expect_v("full_still", 1);
        compare(32'(rmt.ckpt_id));
        compare(32'(rmt.ckpt_full));

        rmt.br_valid = 1'b1;
        rmt.br_id    = 2'd0;
        tick();
        expect_v("resolve_clears_full", 0);
        compare(32'(rmt.ckpt_full));

        rmt.flush = 1'b1;
        expect_v("flush_accept", 0);
        #1;
        compare(32'(rmt.rn_accept));
        tick();
        expect_v("flush_ckpt_id", 0);
        expect_v("flush_full", 0);
        compare(32'(rmt.ckpt_id));
        compare(32'(rmt.ckpt_full));
        peek_spec(1, 1);

        rmt.ckpt_req = 1'b1;
        tick();
        rmt.ckpt_req = 1'b1;
        set_slot(0, 1, 4, 0, 0, 12);
        expect_v("mp_ckpt_id1", 1);
        #1;
        compare(32'(rmt.ckpt_id));
        tick();
        set_slot(0, 1, 4, 0, 0, 13);
        tick();
        peek_spec(4, 13);
        rmt.ckpt_req = 1'b1;
        set_slot(0, 1, 7, 0, 0, 16);
        tick();
        expect_v("mp_tail_before", 3);
        compare(32'(rmt.ckpt_id));
        rmt.br_valid   = 1'b1;
        rmt.br_id      = 2'd1;
        rmt.br_mispred = 1'b1;
        rmt.ckpt_req   = 1'b1;
        set_slot(0, 1, 4, 0, 0, 17);
        expect_v("mp_accept", 0);
        #1;
        compare(32'(rmt.rn_accept));
        tick();
        peek_spec(4, 12);
        peek_spec(7, 7);
        expect_v("mp_tail_after", 2);
        expect_v("mp_full", 0);
        compare(32'(rmt.ckpt_id));
        compare(32'(rmt.ckpt_full));

        rmt.flush = 1'b1;
        tick();
        set_commit(0, 5, 14);
        tick();
        set_slot(0, 1, 5, 0, 0, 15);
        rmt.ckpt_req = 1'b1;
        tick();
        peek_spec(5, 15);
        expect_v("cm_tail", 1);
        compare(32'(rmt.ckpt_id));
        rmt.flush = 1'b1;
        set_commit(0, 6, 18);
        set_commit(1, 6, 19);
        tick();
        peek_spec(5, 14);
        peek_spec(6, 19);
        expect_v("cmflush_full", 0);
        expect_v("cmflush_ckpt_id", 0);
        compare(32'(rmt.ckpt_full));
        compare(32'(rmt.ckpt_id));

        rmt.ckpt_req = 1'b1;
        set_slot(0, 1, 1, 0, 0, 20);
        tick();
        rmt.flush      = 1'b1;
        rmt.br_valid   = 1'b1;
        rmt.br_id      = 2'd0;
        rmt.br_mispred = 1'b1;
        rmt.ckpt_req   = 1'b1;
        set_slot(0, 1, 2, 0, 0, 22);
        expect_v("combo_accept", 0);
        #1;
        compare(32'(rmt.rn_accept));
        tick();
        peek_spec(1, 1);
        peek_spec(2, 2);
        peek_spec(5, 14);
        expect_v("combo_ckpt_id", 0);
        compare(32'(rmt.ckpt_id));

        set_slot(0, 1, 3, 0, 0, 23);
        rmt.ckpt_req = 1'b1;
        tick();
        peek_spec(3, 23);
        expect_v("prerst_ckpt_id", 1);
        compare(32'(rmt.ckpt_id));
        #2 rst = 1'b0;
        #1;
        peek_spec(3, 3);
        expect_v("midrst_ckpt_id", 0);
        expect_v("midrst_full", 0);
        compare(32'(rmt.ckpt_id));
        compare(32'(rmt.ckpt_full));
        @(posedge clk);
        #1 rst = 1'b1;
        rmt.flush = 1'b1;
        tick();
        peek_spec(5, 5);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
